memoria_instrucoes_prog: RTL and testbench

MEMORIA_INSTRUCOES_PROG -- requirements
Module: memoria_instrucoes_prog

---
 rtl/nrisc_pkg.sv | 24 ++
 rtl/memoria_instrucoes_prog_if.sv | 34 +++
 rtl/ram_sync_1r1w.sv | 28 ++
 rtl/memoria_instrucoes_prog.sv | 120 ++++++++++++
 tb/tb_memoria_instrucoes_prog.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nrisc_pkg.sv
// nrisc_pkg -- shared definitions for the NRISC instruction store.
//   NRISC_DATA_W / NRISC_ADDR_W : default instruction word and address widths
//   NRISC_NOP_WORD              : default word returned on an out-of-range fetch
//   prog_state_t                : RUN / PROG mode of the programmable memory
//   idx_width()                 : index width needed to address a given depth
package nrisc_pkg;

  localparam int NRISC_DATA_W = 8;
  localparam int NRISC_ADDR_W = 8;
  localparam int NRISC_DEPTH  = 256;

  localparam logic [NRISC_DATA_W-1:0] NRISC_NOP_WORD = '0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PROG = 1'b1
  } prog_state_t;

  // A depth of 1 still needs a 1-bit index so port widths never collapse to 0.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/memoria_instrucoes_prog_if.sv
// memoria_instrucoes_prog_if -- fetch and programming signals of the
// instruction memory.
//   master : drives fetch_req/endereco and the prog_* controls, receives results
//   slave  : the memory; returns out/fetch_valid/fault and programming status
interface memoria_instrucoes_prog_if #(
  parameter int DATA_W = nrisc_pkg::NRISC_DATA_W,
  parameter int ADDR_W = nrisc_pkg::NRISC_ADDR_W
) ();

  logic              fetch_req;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] out;
  logic              fetch_valid;
  logic              fault;

  logic              prog_start;
  logic              prog_we;
  logic [DATA_W-1:0] prog_data;
  logic              prog_end;
  logic              prog_busy;
  logic              prog_done;
  logic [ADDR_W:0]   prog_count;

  modport master (
    output fetch_req, endereco, prog_start, prog_we, prog_data, prog_end,
    input  out, fetch_valid, fault, prog_busy, prog_done, prog_count
  );

  modport slave (
    input  fetch_req, endereco, prog_start, prog_we, prog_data, prog_end,
    output out, fetch_valid, fault, prog_busy, prog_done, prog_count
  );

endinterface

// File: rtl/ram_sync_1r1w.sv
// ram_sync_1r1w -- DEPTH x DATA_W storage, one synchronous read port and one
// write port, both on the rising clock edge. No reset: contents survive a
// reset of the surrounding logic.
//   clock       : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata updates only when re is high
module ram_sync_1r1w #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/memoria_instrucoes_prog.sv
// memoria_instrucoes_prog -- programmable instruction memory.
// In RUN the memory serves fetches; in PROG words are written sequentially
// from address 0 through an internal pointer.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : fetch port (fetch_req, endereco -> out, fetch_valid, fault)
//                  and programming port (prog_start, prog_we, prog_data,
//                  prog_end -> prog_busy, prog_done, prog_count)
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_RUN  | fetches accepted, writes ignored
//   ST_PROG | writes accepted at the pointer, fetches ignored
module memoria_instrucoes_prog
  import nrisc_pkg::*;
#(
  parameter int                DATA_W   = NRISC_DATA_W,
  parameter int                ADDR_W   = NRISC_ADDR_W,
  parameter int                DEPTH    = NRISC_DEPTH,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NRISC_NOP_WORD)
) (
  input logic                     clock,
  input logic                     reset,
  memoria_instrucoes_prog_if.slave bus
);

  localparam int              IDX_W   = idx_width(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  prog_state_t       state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              in_range;
  logic              fetch_go;
  logic              wr_go;
  logic [DATA_W-1:0] ram_q;

  // Stage 1 of a fetch: RAM read issued, range result remembered.
  logic              pend_valid_q;
  logic              pend_fault_q;

  // Stage 2: registered outputs.
  logic [DATA_W-1:0] out_q;
  logic              valid_q;
  logic              fault_q;

  assign in_range = ({1'b0, bus.endereco} < DEPTH_C);
  // prog_start outranks a simultaneous fetch, so the fetch is dropped.
  assign fetch_go = (state_q == ST_RUN) && bus.fetch_req && !bus.prog_start;
  assign wr_go    = (state_q == ST_PROG) && bus.prog_we;

  ram_sync_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (IDX_W)
  ) u_ram (
    .clock (clock),
    .we    (wr_go),
    .waddr (cnt_q[IDX_W-1:0]),
    .wdata (bus.prog_data),
    .re    (fetch_go && in_range),
    .raddr (bus.endereco[IDX_W-1:0]),
    .rdata (ram_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.prog_start) begin
          state_d = ST_PROG;
          cnt_d   = '0;
        end
      end
      ST_PROG: begin
        if (bus.prog_we) cnt_d = cnt_q + ONE_C;
        // A write into the last address closes the session; the pointer never wraps.
        if (bus.prog_end || (bus.prog_we && (cnt_q == LAST_C))) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_fault_q <= 1'b0;
      out_q        <= '0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      pend_valid_q <= fetch_go;
      pend_fault_q <= fetch_go && !in_range;
      valid_q      <= pend_valid_q;
      fault_q      <= pend_valid_q && pend_fault_q;
      if (pend_valid_q) out_q <= pend_fault_q ? NOP_WORD : ram_q;
    end
  end

  assign bus.out         = out_q;
  assign bus.fetch_valid = valid_q;
  assign bus.fault       = fault_q;
  assign bus.prog_busy   = (state_q == ST_PROG);
  assign bus.prog_done   = done_q;
  assign bus.prog_count  = cnt_q;

endmodule

// File: tb/tb_memoria_instrucoes_prog.sv
// tb_memoria_instrucoes_prog -- bench for memoria_instrucoes_prog.
// dut_a (DEPTH=11) is tracked cycle by cycle against a behavioural model;
// dut_b (DEPTH=4) covers the auto-exit on a full memory.
module tb_memoria_instrucoes_prog;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DA = 11;
  localparam int DB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  memoria_instrucoes_prog_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  memoria_instrucoes_prog_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  memoria_instrucoes_prog #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DA), .NOP_WORD(8'h00)) dut_a (
    .clock (clock), .reset (reset), .bus (bus_a)
  );
  memoria_instrucoes_prog #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DB), .NOP_WORD(8'h00)) dut_b (
    .clock (clock), .reset (reset), .bus (bus_b)
  );

  int total = 0;
  int bad   = 0;

  // model of dut_a
  logic [DW-1:0] m_mem [256];
  bit            m_prog;
  int            m_cnt;
  bit            m_done;
  bit            p_valid, p_fault;
  logic [DW-1:0] p_data;
  bit            e_valid, e_fault;
  logic [DW-1:0] e_out;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp_out;
    logic       exp_fault;
  } fvec_t;
  fvec_t fv [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus_a.fetch_req = 0; bus_a.endereco = '0; bus_a.prog_start = 0;
    bus_a.prog_we = 0; bus_a.prog_data = '0; bus_a.prog_end = 0;
    bus_b.fetch_req = 0; bus_b.endereco = '0; bus_b.prog_start = 0;
    bus_b.prog_we = 0; bus_b.prog_data = '0; bus_b.prog_end = 0;
  endtask

  task automatic model_reset();
    m_prog = 0; m_cnt = 0; m_done = 0;
    p_valid = 0; p_fault = 0; p_data = '0;
    e_valid = 0; e_fault = 0; e_out = '0;
  endtask

  // Advance one clock; the model consumes dut_a's current inputs, then every
  // dut_a output is compared.
  task automatic tick();
    bit acc;
    e_valid = p_valid;
    e_fault = p_valid && p_fault;
    if (p_valid) e_out = p_fault ? 8'h00 : p_data;
    acc = !m_prog && bus_a.fetch_req && !bus_a.prog_start;
    p_valid = acc;
    p_fault = acc && (int'(bus_a.endereco) >= DA);
    if (acc && !p_fault) p_data = m_mem[bus_a.endereco];
    m_done = 0;
    if (!m_prog) begin
      if (bus_a.prog_start) begin m_prog = 1; m_cnt = 0; end
    end else begin
      if (bus_a.prog_we) begin m_mem[m_cnt[7:0]] = bus_a.prog_data; m_cnt++; end
      if (bus_a.prog_end || m_cnt == DA) begin m_prog = 0; m_done = 1; end
    end
    @(posedge clock); #1;
    check("mdl_valid", 32'(bus_a.fetch_valid), 32'(e_valid));
    check("mdl_fault", 32'(bus_a.fault), 32'(e_fault));
    check("mdl_out", 32'(bus_a.out), 32'(e_out));
    check("mdl_busy", 32'(bus_a.prog_busy), 32'(m_prog));
    check("mdl_done", 32'(bus_a.prog_done), 32'(m_done));
    check("mdl_count", 32'(bus_a.prog_count), 32'(m_cnt));
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    #2;
    check("rst_out", 32'(bus_a.out), 32'h0);
    check("rst_valid", 32'(bus_a.fetch_valid), 32'h0);
    check("rst_fault", 32'(bus_a.fault), 32'h0);
    check("rst_busy", 32'(bus_a.prog_busy), 32'h0);
    check("rst_done", 32'(bus_a.prog_done), 32'h0);
    check("rst_count", 32'(bus_a.prog_count), 32'h0);
    @(posedge clock); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic fetch_a(input string nm, input logic [7:0] addr,
                         input logic [7:0] exp, input logic expf);
    bus_a.fetch_req = 1; bus_a.endereco = addr;
    tick();
    bus_a.fetch_req = 0;
    tick();
    check({nm, "_out"}, 32'(bus_a.out), 32'(exp));
    check({nm, "_valid"}, 32'(bus_a.fetch_valid), 32'h1);
    check({nm, "_fault"}, 32'(bus_a.fault), 32'(expf));
  endtask

  task automatic fetch_b(input string nm, input logic [7:0] addr,
                         input logic [7:0] exp, input logic expf);
    bus_b.fetch_req = 1; bus_b.endereco = addr;
    tick();
    bus_b.fetch_req = 0;
    tick();
    check({nm, "_out"}, 32'(bus_b.out), 32'(exp));
    check({nm, "_valid"}, 32'(bus_b.fetch_valid), 32'h1);
    check({nm, "_fault"}, 32'(bus_b.fault), 32'(expf));
  endtask

  initial begin
    fv[0] = '{8'd0,   8'h11, 1'b0};
    fv[1] = '{8'd1,   8'h11, 1'b0};
    fv[2] = '{8'd2,   8'h72, 1'b0};
    fv[3] = '{8'd3,   8'hA3, 1'b0};
    fv[4] = '{8'd10,  8'hAA, 1'b0};
    fv[5] = '{8'd11,  8'h00, 1'b1};
    fv[6] = '{8'd20,  8'h00, 1'b1};
    fv[7] = '{8'd255, 8'h00, 1'b1};
    fv[8] = '{8'd5,   8'hA5, 1'b0};

    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    idle_inputs();
    model_reset();
    @(posedge clock); #1;
    do_reset();

    // Fill all 11 words of dut_a; the last write ends the session on its own.
    bus_a.prog_start = 1; tick(); bus_a.prog_start = 0;
    check("fill_busy", 32'(bus_a.prog_busy), 32'h1);
    for (int i = 0; i < DA; i++) begin
      bus_a.prog_we = 1; bus_a.prog_data = 8'(8'hA0 + i);
      tick();
    end
    bus_a.prog_we = 0;
    check("fill_done", 32'(bus_a.prog_done), 32'h1);
    check("fill_count", 32'(bus_a.prog_count), 32'd11);
    check("fill_busy_off", 32'(bus_a.prog_busy), 32'h0);
    // write in RUN must be ignored
    bus_a.prog_we = 1; bus_a.prog_data = 8'hFF; tick(); bus_a.prog_we = 0;
    check("fill_done_pulse", 32'(bus_a.prog_done), 32'h0);

    // Program 0x11, 0x11, 0x72 then prog_end.
    bus_a.prog_start = 1; tick(); bus_a.prog_start = 0;
    bus_a.prog_we = 1; bus_a.prog_data = 8'h11; tick();
    bus_a.prog_data = 8'h11; tick();
    bus_a.prog_data = 8'h72; tick();
    bus_a.prog_we = 0; bus_a.prog_end = 1; tick(); bus_a.prog_end = 0;
    check("prog3_done", 32'(bus_a.prog_done), 32'h1);
    check("prog3_count", 32'(bus_a.prog_count), 32'd3);
    tick(); tick();
    check("prog3_hold_count", 32'(bus_a.prog_count), 32'd3);
    check("prog3_done_low", 32'(bus_a.prog_done), 32'h0);

    for (int i = 0; i < 9; i++)
      fetch_a($sformatf("tbl%0d", i), fv[i].addr, fv[i].exp_out, fv[i].exp_fault);

    // Stall: out holds, no valid.
    tick();
    check("stall_valid", 32'(bus_a.fetch_valid), 32'h0);
    check("stall_out", 32'(bus_a.out), 32'hA5);

    // fetch together with prog_start: fetch dropped
    bus_a.fetch_req = 1; bus_a.endereco = 8'd0; bus_a.prog_start = 1; tick();
    bus_a.prog_start = 0; bus_a.endereco = 8'd2;
    tick();
    check("start_fetch_valid", 32'(bus_a.fetch_valid), 32'h0);
    check("start_fetch_out", 32'(bus_a.out), 32'hA5);
    tick();
    check("prog_fetch_valid", 32'(bus_a.fetch_valid), 32'h0);
    // write and prog_end together: write lands, then exit
    bus_a.fetch_req = 0; bus_a.prog_we = 1; bus_a.prog_data = 8'h5C; bus_a.prog_end = 1;
    tick();
    bus_a.prog_we = 0; bus_a.prog_end = 0;
    check("prog_fetch_valid2", 32'(bus_a.fetch_valid), 32'h0);
    check("prog_fetch_out", 32'(bus_a.out), 32'hA5);
    check("we_end_done", 32'(bus_a.prog_done), 32'h1);
    check("we_end_count", 32'(bus_a.prog_count), 32'd1);
    fetch_a("we_end_word", 8'd0, 8'h5C, 1'b0);

    // Reset after 2 of 5 writes: session aborted, words kept.
    bus_a.prog_start = 1; tick(); bus_a.prog_start = 0;
    bus_a.prog_we = 1; bus_a.prog_data = 8'hC1; tick();
    bus_a.prog_data = 8'hC2; tick();
    bus_a.prog_data = 8'hC3;
    do_reset();
    check("abort_busy", 32'(bus_a.prog_busy), 32'h0);
    fetch_a("abort_w1", 8'd1, 8'hC2, 1'b0);
    fetch_a("abort_w0", 8'd0, 8'hC1, 1'b0);
    fetch_a("abort_w2", 8'd2, 8'h72, 1'b0);

    // dut_b: DEPTH=4, four writes without prog_end.
    bus_b.prog_start = 1; tick(); bus_b.prog_start = 0;
    for (int i = 0; i < DB; i++) begin
      check($sformatf("b_busy%0d", i), 32'(bus_b.prog_busy), 32'h1);
      bus_b.prog_we = 1; bus_b.prog_data = 8'(8'hB0 + i);
      tick();
    end
    bus_b.prog_we = 0;
    check("b_done", 32'(bus_b.prog_done), 32'h1);
    check("b_count", 32'(bus_b.prog_count), 32'd4);
    check("b_busy_off", 32'(bus_b.prog_busy), 32'h0);
    bus_b.prog_we = 1; bus_b.prog_data = 8'hEE; tick(); bus_b.prog_we = 0;
    check("b_done_pulse", 32'(bus_b.prog_done), 32'h0);
    check("b_count_hold", 32'(bus_b.prog_count), 32'd4);
    fetch_b("b_w0", 8'd0, 8'hB0, 1'b0);
    fetch_b("b_w3", 8'd3, 8'hB3, 1'b0);
    fetch_b("b_oor", 8'd4, 8'h00, 1'b1);

    // Random traffic on dut_a against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        bus_a.fetch_req  = ($urandom_range(0, 1) == 1);
        bus_a.endereco   = 8'($urandom_range(0, 15));
        bus_a.prog_start = ($urandom_range(0, 15) == 0);
        bus_a.prog_we    = ($urandom_range(0, 1) == 1);
        bus_a.prog_data  = 8'($urandom);
        bus_a.prog_end   = ($urandom_range(0, 11) == 0);
        tick();
      end
    end
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
